// File: rtl/cpu_run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl_pkg
// Shared types and constants for the CPU run/step controller.
//   CNT_W        : width of the cycle and remaining-cycle counters
//   run_state_e  : controller run state, as exported on run_state
//   cmd_op_e     : touchscreen command opcodes carried on cmd_op
// -----------------------------------------------------------------------------
package cpu_run_ctrl_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        ST_HALT     = 2'd0,
        ST_RUN_N    = 2'd1,
        ST_RUN_FREE = 2'd2
    } run_state_e;

    typedef enum logic [1:0] {
        OP_HALT     = 2'd0,
        OP_RUN_N    = 2'd1,
        OP_RUN_FREE = 2'd2,
        OP_SET_BP   = 2'd3
    } cmd_op_e;

endpackage

// File: rtl/run_ctrl_debounce.sv
// -----------------------------------------------------------------------------
// run_ctrl_debounce
// Push-button conditioning: two-flop synchronizer, debounce down-counter and
// a one-cycle pulse on each debounced rising edge.
//   clk     in  system clock
//   resetn  in  asynchronous active-low reset
//   btn     in  raw button level, asynchronous to clk
//   press   out one-cycle pulse when the debounced level goes 0 -> 1
// Parameter DEBOUNCE_CYCLES: equal synchronized samples needed before the
// debounced level follows the button.
// -----------------------------------------------------------------------------
module run_ctrl_debounce #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic          level_d;
    logic [CW-1:0] timer;

    // The timer reloads whenever the synchronized input agrees with the
    // debounced level, so only an unbroken run of differing samples reaches
    // terminal count and flips the level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            timer   <= RELOAD;
        end else begin
            sync_a  <= btn;
            sync_b  <= sync_a;
            level_d <= level;
            if (sync_b == level) begin
                timer <= RELOAD;
            end else if (timer == '0) begin
                level <= sync_b;
                timer <= RELOAD;
            end else begin
                timer <= timer - CW'(1);
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
// Run/step controller producing the registered clock enable for the
// multi-cycle CPU. Handles button single-step/stop, touchscreen RUN_N /
// RUN_FREE / HALT / SET_BP commands and an optional PC breakpoint.
//   clk         in   system clock (10 MHz)
//   resetn      in   asynchronous active-low reset
//   btn_step    in   raw push-button level, high = pressed
//   cmd_valid   in   one-cycle command strobe
//   cmd_op      in   command opcode (see cmd_op_e)
//   cmd_arg     in   RUN_N cycle count or SET_BP address
//   cpu_pc      in   CPU fetch PC
//   cpu_clk_en  out  registered CPU clock enable
//   run_state   out  0 HALT, 1 RUN_N, 2 RUN_FREE
//   cycle_cnt   out  enabled CPU cycles since reset (wraps)
//   remain_cnt  out  cycles left in the current RUN_N
//   bp_hit      out  sticky: run stopped by breakpoint
// Build option CPU_RUN_CTRL_BREAKPOINT_EN: when defined, the breakpoint
// register, comparator and prev_pc tracking exist; when undefined SET_BP is
// ignored and bp_hit is tied low.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_HALT     | CPU stopped; a press event gives a single one-cycle enable
// ST_RUN_N    | bounded run, remain_cnt counts down to the last enable
// ST_RUN_FREE | enable every cycle until HALT, press or breakpoint
// -----------------------------------------------------------------------------
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             btn_step,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [31:0]      cmd_arg,
    input  logic [31:0]      cpu_pc,
    output logic             cpu_clk_en,
    output logic [1:0]       run_state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] remain_cnt,
    output logic             bp_hit
);

    run_state_e       state_q, state_d;
    logic             en_q, en_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             press;
    logic             bp_trig;

    run_ctrl_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .resetn (resetn),
        .btn    (btn_step),
        .press  (press)
    );

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    logic        bp_hit_q, bp_hit_d;
    logic        bp_armed_q, bp_armed_d;
    logic [31:0] bp_addr_q, bp_addr_d;
    logic [31:0] prev_pc_q;

    // Fire only on arrival at bp_addr so a run restarted while sitting on the
    // breakpoint address can move off it.
    assign bp_trig = bp_armed_q && (state_q != ST_HALT) &&
                     (cpu_pc == bp_addr_q) && (prev_pc_q != bp_addr_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bp_hit_q   <= 1'b0;
            bp_armed_q <= 1'b0;
            bp_addr_q  <= '0;
            prev_pc_q  <= '0;
        end else begin
            bp_hit_q   <= bp_hit_d;
            bp_armed_q <= bp_armed_d;
            bp_addr_q  <= bp_addr_d;
            prev_pc_q  <= cpu_pc;
        end
    end

    assign bp_hit = bp_hit_q;
`else
    logic unused_pc;

    assign unused_pc = ^cpu_pc;
    assign bp_trig   = 1'b0;
    assign bp_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_HALT;
            en_q        <= 1'b0;
            remain_q    <= '0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            remain_q    <= remain_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    // Baseline behaviour of the current state is computed first, then
    // overridden in increasing priority: press, breakpoint, command.
    always_comb begin
        state_d     = state_q;
        en_d        = 1'b0;
        remain_d    = remain_q;
        cycle_cnt_d = cycle_cnt_q + CNT_W'(en_q);
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        bp_hit_d    = bp_hit_q;
        bp_armed_d  = bp_armed_q;
        bp_addr_d   = bp_addr_q;
`endif

        case (state_q)
            ST_RUN_FREE: en_d = 1'b1;
            ST_RUN_N: begin
                if (remain_q == '0) begin
                    state_d = ST_HALT;
                end else begin
                    remain_d = remain_q - CNT_W'(1);
                    en_d     = 1'b1;
                end
            end
            default: en_d = 1'b0;
        endcase

        if (cmd_valid) begin
            case (cmd_op_e'(cmd_op))
                OP_HALT: begin
                    state_d = ST_HALT;
                    en_d    = 1'b0;
                end
                OP_RUN_N: begin
                    if (cmd_arg != '0) begin
                        state_d  = ST_RUN_N;
                        remain_d = cmd_arg - CNT_W'(1);
                        en_d     = 1'b1;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
                        bp_hit_d = 1'b0;
`endif
                    end
                end
                OP_RUN_FREE: begin
                    state_d = ST_RUN_FREE;
                    en_d    = 1'b1;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
                    bp_hit_d = 1'b0;
`endif
                end
                OP_SET_BP: begin
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
                    bp_addr_d  = cmd_arg;
                    bp_armed_d = 1'b1;
                    bp_hit_d   = 1'b0;
`endif
                end
                default: ;
            endcase
        end else if (bp_trig) begin
            state_d = ST_HALT;
            en_d    = 1'b0;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
            bp_hit_d = 1'b1;
`endif
        end else if (press) begin
            if (state_q == ST_HALT) begin
                en_d = 1'b1;
            end else begin
                state_d = ST_HALT;
                en_d    = 1'b0;
            end
        end
    end

    assign cpu_clk_en = en_q;
    assign run_state  = state_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign remain_cnt = remain_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_run_ctrl
// Directed bench for cpu_run_ctrl with a short debounce window. Inputs change
// 1 ns after the rising edge and outputs are sampled there too. The CPU PC
// model advances by 4 whenever the enable is high after an edge.
// -----------------------------------------------------------------------------
module tb_cpu_run_ctrl;
    import cpu_run_ctrl_pkg::*;

    localparam int DB = 8;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        btn_step;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic [31:0] cpu_pc;
    logic        cpu_clk_en;
    logic [1:0]  run_state;
    logic [31:0] cycle_cnt;
    logic [31:0] remain_cnt;
    logic        bp_hit;

    int  errors = 0;
    int  checks = 0;
    int  pulses;
    int  first;
    int  n;
    logic pc_follow = 1'b0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .btn_step   (btn_step),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .cpu_pc     (cpu_pc),
        .cpu_clk_en (cpu_clk_en),
        .run_state  (run_state),
        .cycle_cnt  (cycle_cnt),
        .remain_cnt (remain_cnt),
        .bp_hit     (bp_hit)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pc_follow && cpu_clk_en) cpu_pc = cpu_pc + 32'd4;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn    = 1'b0;
        btn_step  = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_arg   = '0;
        cpu_pc    = '0;
        repeat (3) tick();

        check_eq("rst_en",     32'(cpu_clk_en), 32'd0);
        check_eq("rst_state",  32'(run_state),  32'd0);
        check_eq("rst_cycle",  cycle_cnt,       32'd0);
        check_eq("rst_remain", remain_cnt,      32'd0);
        check_eq("rst_bp_hit", 32'(bp_hit),     32'd0);

        resetn = 1'b1;
        tick();

        // Held press: one step, en appears DB+3 ticks after the level change.
        pulses = 0;
        first  = -1;
        btn_step = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == DB + 5) btn_step = 1'b0;
            if (cpu_clk_en) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        check_eq("step_pulses",  pulses,          32'd1);
        check_eq("step_latency", first,           DB + 3);
        check_eq("step_cycle",   cycle_cnt,       32'd1);
        check_eq("step_state",   32'(run_state),  32'd0);

        // Bounce shorter than the debounce window.
        pulses = 0;
        btn_step = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 5) btn_step = 1'b0;
            if (cpu_clk_en) pulses++;
        end
        check_eq("bounce_pulses", pulses, 32'd0);

        // RUN_N 5
        send(OP_RUN_N, 32'd5);
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("runn_en_%0d", k),     32'(cpu_clk_en), 32'd1);
            check_eq($sformatf("runn_remain_%0d", k), remain_cnt,      32'(4 - k));
            check_eq($sformatf("runn_state_%0d", k),  32'(run_state),  32'd1);
            tick();
        end
        check_eq("runn_end_en",    32'(cpu_clk_en), 32'd0);
        check_eq("runn_end_state", 32'(run_state),  32'd0);
        check_eq("runn_cycle",     cycle_cnt,       32'd6);

        // RUN_N 0 is a no-op
        send(OP_RUN_N, 32'd0);
        check_eq("run0_en",    32'(cpu_clk_en), 32'd0);
        check_eq("run0_state", 32'(run_state),  32'd0);
        tick();
        check_eq("run0_en2",   32'(cpu_clk_en), 32'd0);
        check_eq("run0_cycle", cycle_cnt,       32'd6);

        // RUN_FREE stopped by HALT issued 20 cycles after the RUN_FREE
        send(OP_RUN_FREE, 32'd0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (cpu_clk_en) n++;
            if (i == 19) begin
                cmd_valid = 1'b1;
                cmd_op    = OP_HALT;
            end
            tick();
        end
        cmd_valid = 1'b0;
        check_eq("free_count", n,               32'd20);
        check_eq("free_en",    32'(cpu_clk_en), 32'd0);
        check_eq("free_state", 32'(run_state),  32'd0);
        check_eq("free_cycle", cycle_cnt,       32'd26);

        // RUN_FREE stopped by a press event
        send(OP_RUN_FREE, 32'd0);
        btn_step = 1'b1;
        n = 0;
        for (int i = 0; i <= DB + 2; i++) begin
            check_eq($sformatf("pstop_state_%0d", i), 32'(run_state), 32'd2);
            if (cpu_clk_en) n++;
            tick();
        end
        check_eq("pstop_count", n,               32'(DB + 3));
        check_eq("pstop_en",    32'(cpu_clk_en), 32'd0);
        check_eq("pstop_state", 32'(run_state),  32'd0);
        check_eq("pstop_cycle", cycle_cnt,       32'd37);
        btn_step = 1'b0;
        repeat (20) tick();
        check_eq("pstop_release_en", 32'(cpu_clk_en), 32'd0);

        // Breakpoint at 0x10 while free running
        cpu_pc = '0;
        send(OP_SET_BP, 32'h0000_0010);
        pc_follow = 1'b1;
        send(OP_RUN_FREE, 32'd0);
        for (int i = 0; i < 20 && cpu_pc != 32'h10; i++) tick();
        check_eq("bp_reach_pc", cpu_pc, 32'h10);
        tick();
        check_eq("bp_en",     32'(cpu_clk_en), BP_EN ? 32'd0 : 32'd1);
        check_eq("bp_hit",    32'(bp_hit),     BP_EN ? 32'd1 : 32'd0);
        check_eq("bp_state",  32'(run_state),  BP_EN ? 32'd0 : 32'd2);
        check_eq("bp_hold_pc", cpu_pc,         BP_EN ? 32'h10 : 32'h14);
        send(OP_RUN_FREE, 32'd0);
        check_eq("bp_resume_hit", 32'(bp_hit),     32'd0);
        check_eq("bp_resume_en",  32'(cpu_clk_en), 32'd1);
        repeat (3) tick();
        check_eq("bp_past_pc",    32'(cpu_pc > 32'h10), 32'd1);
        check_eq("bp_past_en",    32'(cpu_clk_en),      32'd1);
        check_eq("bp_past_hit",   32'(bp_hit),          32'd0);
        send(OP_HALT, 32'd0);
        pc_follow = 1'b0;
        check_eq("bp_halt_en", 32'(cpu_clk_en), 32'd0);

        // Command and press event in the same cycle: press is dropped
        btn_step = 1'b1;
        repeat (DB + 2) tick();
        send(OP_RUN_N, 32'd3);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (cpu_clk_en) n++;
            tick();
        end
        check_eq("cmdpress_count", n,              32'd3);
        check_eq("cmdpress_state", 32'(run_state), 32'd0);
        btn_step = 1'b0;
        repeat (20) tick();

        // cycle_cnt wrap
        force dut.cycle_cnt_q = 32'hFFFF_FFFE;
        tick();
        release dut.cycle_cnt_q;
        check_eq("wrap_preset", cycle_cnt, 32'hFFFF_FFFE);
        send(OP_RUN_N, 32'd3);
        check_eq("wrap_c0", cycle_cnt, 32'hFFFF_FFFE);
        tick();
        check_eq("wrap_c1", cycle_cnt, 32'hFFFF_FFFF);
        tick();
        check_eq("wrap_zero", cycle_cnt, 32'h0000_0000);
        tick();
        check_eq("wrap_one", cycle_cnt, 32'h0000_0001);
        check_eq("wrap_en",  32'(cpu_clk_en), 32'd0);

        // Reset in the middle of RUN_N 100
        send(OP_RUN_N, 32'd100);
        repeat (5) tick();
        check_eq("mid_en",     32'(cpu_clk_en), 32'd1);
        check_eq("mid_remain", remain_cnt,      32'd94);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("arst_en",     32'(cpu_clk_en), 32'd0);
        check_eq("arst_state",  32'(run_state),  32'd0);
        check_eq("arst_cycle",  cycle_cnt,       32'd0);
        check_eq("arst_remain", remain_cnt,      32'd0);
        check_eq("arst_bp_hit", 32'(bp_hit),     32'd0);
        repeat (2) tick();
        resetn = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cpu_clk_en) n++;
        end
        check_eq("post_rst_en_count", n,              32'd0);
        check_eq("post_rst_state",    32'(run_state), 32'd0);
        check_eq("post_rst_cycle",    cycle_cnt,      32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
